// File: rtl/bin2bcd_seq.sv
// ---------------------------------------------------------------------------
// bin2bcd_seq
// Iterative binary-to-BCD converter using the double-dabble algorithm. Each
// clock performs one add-3/shift step, so a W-bit operand takes W shift
// cycles plus one DONE cycle. This is the lower-area successor to the
// combinational bin2bcd.
//
// Parameters
//   W   : binary input width (W >= 4)
//   ND  : number of BCD digits, derived from W (not overridable)
//
// Ports
//   Clk    : system clock, rising-edge active
//   Rst_n  : synchronous active-low reset
//   Start  : conversion request, only honoured in IDLE
//   Bin    : binary operand, captured when Start is accepted
//   Busy   : high while the shift sequence is running
//   Done   : one-cycle pulse when Bcd holds a fresh result
//   Bcd    : registered result {digit ND-1, ..., tens, ones}
//   Neg    : sign of the result (only with BIN2BCD_SEQ_SIGNED_EN)
//
// Optional feature
//   BIN2BCD_SEQ_SIGNED_EN : treat Bin as two's complement, convert its
//   magnitude and report the sign on Neg. Undefined: Bin is unsigned and
//   the Neg port is absent.
// ---------------------------------------------------------------------------
module bin2bcd_seq #(
   parameter  int W  = 32,
   localparam int ND = (W + (W - 4) / 3) / 4 + 1
) (
   input  logic            Clk,
   input  logic            Rst_n,
   input  logic            Start,
   input  logic [W-1:0]    Bin,
   output logic            Busy,
   output logic            Done,
   output logic [4*ND-1:0] Bcd
`ifdef BIN2BCD_SEQ_SIGNED_EN
   ,
   output logic            Neg
`endif
);

   localparam int BW = 4 * ND;
   localparam int CW = $clog2(W);

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      DONE
   } state_t;

   state_t          state_q, state_d;
   logic [BW-1:0]   acc_q, acc_d;
   logic [W-1:0]    opnd_q, opnd_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [BW-1:0]   bcd_q, bcd_d;
   logic            busy_q, busy_d;
   logic            done_q, done_d;
   logic [BW-1:0]   adj;
   logic [W-1:0]    load_val;
`ifdef BIN2BCD_SEQ_SIGNED_EN
   logic            sign_q, sign_d;
   logic            neg_q, neg_d;
`endif

   // Operand loaded on Start. In signed mode the magnitude is taken as a
   // W-bit unsigned value, so the most negative input maps to 2^(W-1).
   always_comb begin
`ifdef BIN2BCD_SEQ_SIGNED_EN
      load_val = Bin[W-1] ? (~Bin + 1'b1) : Bin;
`else
      load_val = Bin;
`endif
   end

   // Add-3 correction: each accumulator digit above 4 gets +3 so that the
   // following left shift carries correctly into the next decimal digit.
   // The add is confined to the 4-bit digit; no carry crosses digits.
   always_comb begin
      adj = acc_q;
      for (int i = 0; i < ND; i++) begin
         if (acc_q[4*i +: 4] > 4'd4) begin
            adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
         end
      end
   end

   // Next-state logic for the FSM and datapath. The result register is
   // loaded on the final shift so that Bcd and Done appear together in the
   // DONE cycle, while the accumulator keeps Bcd stable during SHIFT.
   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      opnd_d  = opnd_q;
      cnt_d   = cnt_q;
      bcd_d   = bcd_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
`ifdef BIN2BCD_SEQ_SIGNED_EN
      sign_d  = sign_q;
      neg_d   = neg_q;
`endif
      case (state_q)
         IDLE: begin
            if (Start) begin
               opnd_d  = load_val;
               acc_d   = '0;
               cnt_d   = CW'(W - 1);
               busy_d  = 1'b1;
               state_d = SHIFT;
`ifdef BIN2BCD_SEQ_SIGNED_EN
               sign_d  = Bin[W-1];
`endif
            end
         end
         SHIFT: begin
            acc_d  = {adj[BW-2:0], opnd_q[W-1]};
            opnd_d = {opnd_q[W-2:0], 1'b0};
            if (cnt_q == '0) begin
               cnt_d   = '0;
               bcd_d   = {adj[BW-2:0], opnd_q[W-1]};
               busy_d  = 1'b0;
               done_d  = 1'b1;
               state_d = DONE;
`ifdef BIN2BCD_SEQ_SIGNED_EN
               neg_d   = sign_q;
`endif
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   // State register with synchronous active-low reset. Reset mid-conversion
   // simply returns to IDLE, so no Done is ever produced for that request.
   always_ff @(posedge Clk) begin
      if (!Rst_n) begin
         state_q <= IDLE;
         acc_q   <= '0;
         opnd_q  <= '0;
         cnt_q   <= '0;
         bcd_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
`ifdef BIN2BCD_SEQ_SIGNED_EN
         sign_q  <= 1'b0;
         neg_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         opnd_q  <= opnd_d;
         cnt_q   <= cnt_d;
         bcd_q   <= bcd_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
`ifdef BIN2BCD_SEQ_SIGNED_EN
         sign_q  <= sign_d;
         neg_q   <= neg_d;
`endif
      end
   end

   assign Busy = busy_q;
   assign Done = done_q;
   assign Bcd  = bcd_q;
`ifdef BIN2BCD_SEQ_SIGNED_EN
   assign Neg  = neg_q;
`endif

endmodule

// File: tb/tb_bin2bcd_seq.sv
// ---------------------------------------------------------------------------
// tb_bin2bcd_seq
// Self-checking bench for bin2bcd_seq. Two instances are exercised side by
// side: W=8 and W=32. Fixed vectors come from a table, random operands are
// compared against a decimal-digit reference model, and hand-written
// sequences cover Start while busy, Start in the DONE cycle, back-to-back
// requests and reset in the middle of a conversion.
// ---------------------------------------------------------------------------
module tb_bin2bcd_seq;

   localparam int W8   = 8;
   localparam int W32  = 32;
   localparam int ND8  = (W8 + (W8 - 4) / 3) / 4 + 1;
   localparam int ND32 = (W32 + (W32 - 4) / 3) / 4 + 1;
   localparam int LIMIT = 200;

   logic              clk;
   logic              rst_n;
   logic              start8, start32;
   logic [W8-1:0]     bin8;
   logic [W32-1:0]    bin32;
   logic              busy8, busy32;
   logic              done8, done32;
   logic [4*ND8-1:0]  bcd8;
   logic [4*ND32-1:0] bcd32;
`ifdef BIN2BCD_SEQ_SIGNED_EN
   logic              neg8, neg32;
`endif

   int check_count = 0;
   int pass_count  = 0;

   typedef struct {
      int          which;
      logic [31:0] bin;
      logic [63:0] exp_bcd;
      logic        exp_neg;
   } vec_t;

   vec_t vecs[$];

   bin2bcd_seq #(.W(W8)) dut8 (
      .Clk   (clk),
      .Rst_n (rst_n),
      .Start (start8),
      .Bin   (bin8),
      .Busy  (busy8),
      .Done  (done8),
      .Bcd   (bcd8)
`ifdef BIN2BCD_SEQ_SIGNED_EN
      ,
      .Neg   (neg8)
`endif
   );

   bin2bcd_seq #(.W(W32)) dut32 (
      .Clk   (clk),
      .Rst_n (rst_n),
      .Start (start32),
      .Bin   (bin32),
      .Busy  (busy32),
      .Done  (done32),
      .Bcd   (bcd32)
`ifdef BIN2BCD_SEQ_SIGNED_EN
      ,
      .Neg   (neg32)
`endif
   );

   // Free-running clock, 10 time units per period.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Reference: decimal digits of the operand magnitude by repeated
   // division, independent of any shift/add-3 formulation.
   function automatic logic [63:0] ref_bcd(input int w, input logic [31:0] bin,
                                            output logic neg);
      longint unsigned mag;
      logic [63:0]     r;
      mag = (w == W8) ? longint'(bin[7:0]) : longint'(bin);
      neg = 1'b0;
`ifdef BIN2BCD_SEQ_SIGNED_EN
      if (bin[w-1]) begin
         neg = 1'b1;
         mag = (64'd1 << w) - mag;
      end
`endif
      r = '0;
      for (int i = 0; i < 16; i++) begin
         r[4*i +: 4] = 4'(mag % 10);
         mag = mag / 10;
      end
      return r;
   endfunction

   // Compare one observed value with its expectation and keep the tally.
   task automatic checkOutput(input string name, input logic [63:0] act,
                              input logic [63:0] exp);
      check_count++;
      if (act === exp) begin
         pass_count++;
      end else begin
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Pulse Start on one instance and wait (bounded) for Done. Returns the
   // result, the cycle count from the Start edge and how many cycles Busy
   // was high. On return the bench sits in the Done cycle.
   task automatic applyStimulus(input int which, input logic [31:0] bin,
                                output logic [63:0] bcd, output logic neg,
                                output int lat, output int busy_cnt);
      @(negedge clk);
      if (which == W8) begin
         start8 = 1'b1;
         bin8   = bin[7:0];
      end else begin
         start32 = 1'b1;
         bin32   = bin;
      end
      @(negedge clk);
      start8   = 1'b0;
      start32  = 1'b0;
      lat      = 1;
      busy_cnt = 0;
      while (!((which == W8) ? done8 : done32) && lat < LIMIT) begin
         if ((which == W8) ? busy8 : busy32) busy_cnt++;
         @(negedge clk);
         lat++;
      end
      if (lat >= LIMIT) begin
         check_count++;
         $display("[TB] FAIL done_timeout: no Done within %0d cycles (W=%0d)", LIMIT, which);
      end
      bcd = (which == W8) ? 64'(bcd8) : 64'(bcd32);
`ifdef BIN2BCD_SEQ_SIGNED_EN
      neg = (which == W8) ? neg8 : neg32;
`else
      neg = 1'b0;
`endif
   endtask

   // Full conversion check: result, sign, latency, Busy length, Busy low
   // in the Done cycle, and Done dropping after one cycle.
   task automatic runAndCheck(input string tag, input int which, input logic [31:0] bin,
                              input logic [63:0] exp_bcd, input logic exp_neg);
      logic [63:0] bcd;
      logic        neg;
      int          lat, busy_cnt;
      applyStimulus(which, bin, bcd, neg, lat, busy_cnt);
      checkOutput({tag, "_bcd"}, bcd, exp_bcd);
`ifdef BIN2BCD_SEQ_SIGNED_EN
      checkOutput({tag, "_neg"}, 64'(neg), 64'(exp_neg));
`endif
      checkOutput({tag, "_latency"}, 64'(lat), 64'(which + 1));
      checkOutput({tag, "_busy_cycles"}, 64'(busy_cnt), 64'(which));
      checkOutput({tag, "_busy_in_done"}, 64'((which == W8) ? busy8 : busy32), 64'd0);
      @(negedge clk);
      checkOutput({tag, "_done_pulse"}, 64'((which == W8) ? done8 : done32), 64'd0);
   endtask

   initial begin
      logic [63:0] bcd, exp;
      logic        neg, exp_neg;
      int          lat, busy_cnt, done_seen;
      logic [31:0] r;

      rst_n   = 1'b0;
      start8  = 1'b0;
      start32 = 1'b0;
      bin8    = '0;
      bin32   = '0;

      // Hand-computed vectors for both widths.
`ifdef BIN2BCD_SEQ_SIGNED_EN
      vecs.push_back('{W8,  32'h80, 64'h128, 1'b1});
      vecs.push_back('{W8,  32'hFF, 64'h001, 1'b1});
      vecs.push_back('{W8,  32'h7F, 64'h127, 1'b0});
      vecs.push_back('{W8,  32'h00, 64'h000, 1'b0});
      vecs.push_back('{W8,  32'h9C, 64'h100, 1'b1});
      vecs.push_back('{W8,  32'd9,  64'h009, 1'b0});
      vecs.push_back('{W32, 32'hFFFFFFFF, 64'h1, 1'b1});
      vecs.push_back('{W32, 32'h80000000, 64'h2147483648, 1'b1});
      vecs.push_back('{W32, 32'd1000000,  64'h1000000, 1'b0});
`else
      vecs.push_back('{W8,  32'd255, 64'h255, 1'b0});
      vecs.push_back('{W8,  32'd0,   64'h000, 1'b0});
      vecs.push_back('{W8,  32'd9,   64'h009, 1'b0});
      vecs.push_back('{W8,  32'd100, 64'h100, 1'b0});
      vecs.push_back('{W8,  32'd128, 64'h128, 1'b0});
      vecs.push_back('{W8,  32'd99,  64'h099, 1'b0});
      vecs.push_back('{W32, 32'hFFFFFFFF, 64'h04294967295, 1'b0});
      vecs.push_back('{W32, 32'd1000000,  64'h00001000000, 1'b0});
      vecs.push_back('{W32, 32'd0,        64'h0, 1'b0});
`endif

      repeat (3) @(negedge clk);
      checkOutput("reset_busy8",  64'(busy8),  64'd0);
      checkOutput("reset_done8",  64'(done8),  64'd0);
      checkOutput("reset_bcd8",   64'(bcd8),   64'd0);
      checkOutput("reset_busy32", 64'(busy32), 64'd0);
      checkOutput("reset_bcd32",  64'(bcd32),  64'd0);
`ifdef BIN2BCD_SEQ_SIGNED_EN
      checkOutput("reset_neg8",   64'(neg8),   64'd0);
`endif
      rst_n = 1'b1;

      $display("[TB] table vectors");
      foreach (vecs[i]) begin
         runAndCheck($sformatf("vec%0d", i), vecs[i].which, vecs[i].bin,
                     vecs[i].exp_bcd, vecs[i].exp_neg);
      end

      $display("[TB] random operands against reference model");
      for (int i = 0; i < 16; i++) begin
         r   = $urandom;
         exp = ref_bcd(W8, r, exp_neg);
         runAndCheck($sformatf("rand8_%0d", i), W8, r, exp, exp_neg);
      end
      for (int i = 0; i < 8; i++) begin
         r   = $urandom;
         exp = ref_bcd(W32, r, exp_neg);
         runAndCheck($sformatf("rand32_%0d", i), W32, r, exp, exp_neg);
      end

      $display("[TB] back-to-back with Start in the DONE cycle");
      applyStimulus(W8, 32'd0, bcd, neg, lat, busy_cnt);
      checkOutput("b2b_first_bcd", bcd, 64'h000);
      start8 = 1'b1;
      bin8   = 8'd9;
      @(negedge clk);
      start8 = 1'b0;
      checkOutput("done_start_ignored_busy", 64'(busy8), 64'd0);
      done_seen = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (done8 || busy8) done_seen++;
      end
      checkOutput("done_start_no_conversion", 64'(done_seen), 64'd0);
      applyStimulus(W8, 32'd0, bcd, neg, lat, busy_cnt);
      checkOutput("b2b_a_bcd", bcd, 64'h000);
      applyStimulus(W8, 32'd9, bcd, neg, lat, busy_cnt);
      checkOutput("b2b_b_bcd", bcd, 64'h009);
      checkOutput("b2b_b_latency", 64'(lat), 64'(W8 + 1));

      $display("[TB] Start while busy is ignored, Bcd holds during SHIFT");
      @(negedge clk);
      start8 = 1'b1;
      bin8   = 8'd100;
      @(negedge clk);
      start8 = 1'b0;
      @(negedge clk);
      @(negedge clk);
      start8 = 1'b1;
      bin8   = 8'd7;
      checkOutput("hold_bcd_in_shift", 64'(bcd8), 64'h009);
      @(negedge clk);
      start8 = 1'b0;
      done_seen = 0;
      bcd = '0;
      for (int i = 0; i < 20; i++) begin
         if (done8) begin
            done_seen++;
            bcd = 64'(bcd8);
         end
         @(negedge clk);
      end
      checkOutput("busy_start_single_done", 64'(done_seen), 64'd1);
      checkOutput("busy_start_bcd", bcd, 64'h100);
      checkOutput("busy_start_final_bcd", 64'(bcd8), 64'h100);

      $display("[TB] reset in the middle of a conversion");
      start8 = 1'b1;
      bin8   = 8'd55;
      @(negedge clk);
      start8 = 1'b0;
      @(negedge clk);
      @(negedge clk);
      @(negedge clk);
      checkOutput("pre_reset_busy", 64'(busy8), 64'd1);
      rst_n = 1'b0;
      @(negedge clk);
      checkOutput("mid_reset_busy", 64'(busy8), 64'd0);
      checkOutput("mid_reset_done", 64'(done8), 64'd0);
      checkOutput("mid_reset_bcd",  64'(bcd8),  64'd0);
      rst_n = 1'b1;
      done_seen = 0;
      for (int i = 0; i < 14; i++) begin
         @(negedge clk);
         if (done8) done_seen++;
      end
      checkOutput("aborted_no_done", 64'(done_seen), 64'd0);
      exp = ref_bcd(W8, 32'd42, exp_neg);
      runAndCheck("after_reset", W8, 32'd42, exp, exp_neg);

      $display("%0d/%0d checks passed", pass_count, check_count);
      $finish;
   end

endmodule
